// File: rtl/regfile_sb.sv
// Multi-ported register file with write-first read bypass and a per-register
// busy scoreboard for tracking in-flight producers.
module regfile_sb #(
  parameter int XLEN     = 64,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_addr,
  output logic                 iss_ready,
  input  logic                 flush,
  output logic [NREG*XLEN-1:0] dbg_regs
);

  logic [NREG-1:0][XLEN-1:0] regQ;
  logic [NREG-1:0]           busyQ;
  logic [NREG-1:0]           busyNext;

  logic [NRD-1:0][AW-1:0]    rdA;
  logic [NRD-1:0][XLEN-1:0]  rdData;
  logic [NRD-1:0][XLEN-1:0]  rdFwd;
  logic [NRD-1:0]            rdHit;
  logic [NWR-1:0][AW-1:0]    wrA;
  logic [NWR-1:0][XLEN-1:0]  wrD;
  logic                      issHit;
  logic                      issReady;

  assign rdA       = rd_addr;
  assign wrA       = wr_addr;
  assign wrD       = wr_data;
  assign rd_data   = rdData;
  assign dbg_regs  = regQ;
  assign iss_ready = issReady;

  function automatic logic isZero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Scanning ports in ascending order lets the highest-index writer win the bypass.
  always_comb begin
    rdHit = '0;
    rdFwd = '0;
    for (int i = 0; i < NRD; i++) begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wrA[j] == rdA[i])) begin
          rdHit[i] = 1'b1;
          rdFwd[i] = wrD[j];
        end
      end
    end
  end

  always_comb begin
    rdData  = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (isZero(rdA[i]))
        rdData[i] = '0;
      else if (rdHit[i])
        rdData[i] = rdFwd[i];
      else
        rdData[i] = regQ[rdA[i]];
      rd_busy[i] = busyQ[rdA[i]] && !rdHit[i];
    end
  end

  always_comb begin
    issHit = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && (wrA[j] == iss_addr))
        issHit = 1'b1;
    end
    issReady = !flush && (isZero(iss_addr) || !busyQ[iss_addr] || issHit);
  end

  // Write clears first, then issue sets, so a same-cycle issue keeps the bit set.
  always_comb begin
    busyNext = busyQ;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j])
        busyNext[wrA[j]] = 1'b0;
    end
    if (iss_valid && issReady)
      busyNext[iss_addr] = 1'b1;
    if (flush)
      busyNext = '0;
    if (ZERO_REG != 0)
      busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regQ  <= '0;
      busyQ <= '0;
    end else begin
      busyQ <= busyNext;
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && !isZero(wrA[j]))
          regQ[wrA[j]] <= wrD[j];
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb at default parameters.
module tb_regfile_sb;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    wr_addr;
  logic [NWR*XLEN-1:0]  wr_data;
  logic                 iss_valid;
  logic [AW-1:0]        iss_addr;
  logic                 iss_ready;
  logic                 flush;
  logic [NREG*XLEN-1:0] dbg_regs;

  int total = 0;
  int bad   = 0;

  regfile_sb dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .flush(flush), .dbg_regs(dbg_regs)
  );

  always #5 clk = ~clk;

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_valid = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); rd_addr = {5'd5, 5'd3};
    tick(); #1;
    total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL reset_rd_busy got=%b exp=00", rd_busy); end
    total++; if (dbg_regs !== '0) begin bad++; $display("FAIL reset_dbg got nonzero exp=0"); end
    total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL reset_iss_ready got=%b exp=1", iss_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    idle();
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd5; wr_data[0 +: XLEN] = 64'h1234;
    rd_addr = {5'd0, 5'd5};
    #1;
    total++; if (rd_data[0 +: XLEN] !== 64'h1234) begin bad++; $display("FAIL wr_bypass got=%h exp=1234", rd_data[0 +: XLEN]); end
    total++; if (dbg_regs[5*XLEN +: XLEN] !== 64'h0) begin bad++; $display("FAIL dbg_no_bypass got=%h exp=0", dbg_regs[5*XLEN +: XLEN]); end
    tick(); idle(); rd_addr = {5'd5, 5'd0}; #1;
    total++; if (rd_data[XLEN +: XLEN] !== 64'h1234) begin bad++; $display("FAIL rd_port1_x5 got=%h exp=1234", rd_data[XLEN +: XLEN]); end
    total++; if (dbg_regs[5*XLEN +: XLEN] !== 64'h1234) begin bad++; $display("FAIL dbg_x5 got=%h exp=1234", dbg_regs[5*XLEN +: XLEN]); end
  endtask

  task automatic test_same_addr();
    idle();
    wr_en = 2'b11;
    wr_addr = {5'd7, 5'd7};
    wr_data = {64'hBB, 64'hAA};
    rd_addr = {5'd5, 5'd7};
    #1;
    total++; if (rd_data[0 +: XLEN] !== 64'hBB) begin bad++; $display("FAIL same_addr_bypass got=%h exp=bb", rd_data[0 +: XLEN]); end
    total++; if (rd_data[XLEN +: XLEN] !== 64'h1234) begin bad++; $display("FAIL other_port_x5 got=%h exp=1234", rd_data[XLEN +: XLEN]); end
    tick(); idle(); #1;
    total++; if (dbg_regs[7*XLEN +: XLEN] !== 64'hBB) begin bad++; $display("FAIL same_addr_stored got=%h exp=bb", dbg_regs[7*XLEN +: XLEN]); end
    total++; if (rd_data[0 +: XLEN] !== 64'hBB) begin bad++; $display("FAIL same_addr_read got=%h exp=bb", rd_data[0 +: XLEN]); end
  endtask

  task automatic test_zero_reg();
    idle();
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd0; wr_data[0 +: XLEN] = 64'hFFFF;
    rd_addr = {5'd0, 5'd0};
    iss_valid = 1'b1; iss_addr = 5'd0;
    #1;
    total++; if (rd_data[0 +: XLEN] !== 64'h0) begin bad++; $display("FAIL zero_bypass got=%h exp=0", rd_data[0 +: XLEN]); end
    total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL zero_iss_ready got=%b exp=1", iss_ready); end
    tick(); idle(); rd_addr = {5'd0, 5'd0}; #1;
    total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL zero_busy got=%b exp=00", rd_busy); end
    total++; if (dbg_regs[0 +: XLEN] !== 64'h0) begin bad++; $display("FAIL zero_stored got=%h exp=0", dbg_regs[0 +: XLEN]); end
    total++; if (rd_data[XLEN +: XLEN] !== 64'h0) begin bad++; $display("FAIL zero_read got=%h exp=0", rd_data[XLEN +: XLEN]); end
  endtask

  task automatic test_issue();
    idle(); rd_addr = {5'd4, 5'd3};
    iss_valid = 1'b1; iss_addr = 5'd3; #1;
    total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL issue_ready_free got=%b exp=1", iss_ready); end
    tick(); idle(); iss_addr = 5'd3; #1;
    total++; if (rd_busy !== 2'b01) begin bad++; $display("FAIL issue_busy_set got=%b exp=01", rd_busy); end
    total++; if (iss_ready !== 1'b0) begin bad++; $display("FAIL issue_ready_busy got=%b exp=0", iss_ready); end
    wr_en = 2'b10; wr_addr[AW +: AW] = 5'd3; wr_data[XLEN +: XLEN] = 64'h33; #1;
    total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL write_masks_busy got=%b exp=00", rd_busy); end
    total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL write_frees_ready got=%b exp=1", iss_ready); end
    tick(); idle(); #1;
    total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL write_clears_busy got=%b exp=00", rd_busy); end
    total++; if (rd_data[0 +: XLEN] !== 64'h33) begin bad++; $display("FAIL x3_value got=%h exp=33", rd_data[0 +: XLEN]); end
    iss_valid = 1'b1; iss_addr = 5'd3;
    tick(); idle();
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd3; wr_data[0 +: XLEN] = 64'h44;
    iss_valid = 1'b1; iss_addr = 5'd3; #1;
    total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL set_clear_ready got=%b exp=1", iss_ready); end
    tick(); idle(); #1;
    total++; if (rd_busy !== 2'b01) begin bad++; $display("FAIL set_wins got=%b exp=01", rd_busy); end
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd3; wr_data[0 +: XLEN] = 64'h44;
    tick(); idle();
  endtask

  task automatic test_flush();
    idle(); rd_addr = {5'd9, 5'd4};
    iss_valid = 1'b1; iss_addr = 5'd4;
    tick(); iss_addr = 5'd9;
    tick(); idle(); #1;
    total++; if (rd_busy !== 2'b11) begin bad++; $display("FAIL pre_flush_busy got=%b exp=11", rd_busy); end
    flush = 1'b1; iss_valid = 1'b1; iss_addr = 5'd12;
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd4; wr_data[0 +: XLEN] = 64'h55; #1;
    total++; if (iss_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", iss_ready); end
    tick(); idle(); iss_addr = 5'd12; #1;
    total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL flush_clears got=%b exp=00", rd_busy); end
    total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL flush_blocks_issue got=%b exp=1", iss_ready); end
    total++; if (dbg_regs[4*XLEN +: XLEN] !== 64'h55) begin bad++; $display("FAIL flush_write got=%h exp=55", dbg_regs[4*XLEN +: XLEN]); end
  endtask

  task automatic test_async_reset();
    idle(); rd_addr = {5'd7, 5'd10};
    iss_valid = 1'b1; iss_addr = 5'd10;
    tick(); idle(); iss_addr = 5'd10; #1;
    total++; if (rd_busy !== 2'b01) begin bad++; $display("FAIL busy_x10 got=%b exp=01", rd_busy); end
    #1 rst_n = 1'b0; #1;
    total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL arst_busy got=%b exp=00", rd_busy); end
    total++; if (dbg_regs !== '0) begin bad++; $display("FAIL arst_regs got nonzero exp=0"); end
    total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got=%b exp=1", iss_ready); end
    total++; if (rd_data[XLEN +: XLEN] !== 64'h0) begin bad++; $display("FAIL arst_rd_x7 got=%h exp=0", rd_data[XLEN +: XLEN]); end
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd11; wr_data[0 +: XLEN] = 64'h77;
    iss_valid = 1'b1; iss_addr = 5'd11;
    tick(); idle(); rst_n = 1'b1; rd_addr = {5'd11, 5'd11}; iss_addr = 5'd11; #1;
    total++; if (dbg_regs !== '0) begin bad++; $display("FAIL write_in_reset got nonzero exp=0"); end
    total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL issue_in_reset got=%b exp=00", rd_busy); end
    total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b exp=1", iss_ready); end
  endtask

  initial begin
    rst_n = 1'b0; rd_addr = '0; idle();
    test_reset();
    test_write_read();
    test_same_addr();
    test_zero_reg();
    test_issue();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
